// File: rtl/weight_scheduler_if.sv
// Error-path bus between the error combiner and the weight scheduler.
// Handshake: error_valid_i alone qualifies error_comb_i. There is no ready;
// the scheduler consumes a sample on every clock edge where error_valid_i=1.
// Weights, locked_o and state_o flow back to the combiner side.
interface weight_scheduler_if #(
  parameter int WEIGHT_WIDTH = 4,
  parameter int ERROR_WIDTH  = 5
);
  logic signed [ERROR_WIDTH-1:0]  error_comb_i;
  logic                           error_valid_i;
  logic signed [WEIGHT_WIDTH-1:0] weight_0_o;
  logic signed [WEIGHT_WIDTH-1:0] weight_1_o;
  logic signed [WEIGHT_WIDTH-1:0] weight_2_o;
  logic signed [WEIGHT_WIDTH-1:0] weight_3_o;
  logic                           locked_o;
  logic [1:0]                     state_o;

  // Combiner side: produces errors, consumes weights.
  modport master (
    output error_comb_i, error_valid_i,
    input  weight_0_o, weight_1_o, weight_2_o, weight_3_o, locked_o, state_o
  );

  // Scheduler side: consumes errors, produces weights.
  modport slave (
    input  error_comb_i, error_valid_i,
    output weight_0_o, weight_1_o, weight_2_o, weight_3_o, locked_o, state_o
  );
endinterface

// File: rtl/weight_scheduler.sv
// ADPLL weight scheduler: holds the combiner on the coarse detector during
// acquisition, ramps the four weights one step per sample toward the tracking
// blend once lock is seen, and falls back to acquisition on loss of lock.
module weight_scheduler #(
  parameter int WEIGHT_WIDTH  = 4,
  parameter int ERROR_WIDTH   = 5,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_THRESH = 8,
  parameter int UNLOCK_COUNT  = 4,
  parameter int TRK_W0        = 1,
  parameter int TRK_W1        = 2,
  parameter int TRK_W2        = 2,
  parameter int TRK_W3        = 2
) (
  input logic               clk_i,
  input logic               reset_i,
  weight_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'b00,
    ST_SETTLE  = 2'b01,
    ST_TRACK   = 2'b10,
    ST_UNUSED  = 2'b11
  } state_t;

  localparam int WMAX_I = (1 << (WEIGHT_WIDTH - 1)) - 1;

  localparam logic signed [WEIGHT_WIDTH-1:0] WMAX   = WMAX_I[WEIGHT_WIDTH-1:0];
  localparam logic signed [WEIGHT_WIDTH-1:0] WZERO  = '0;
  localparam logic signed [WEIGHT_WIDTH-1:0] WONE   = 1;
  localparam logic signed [WEIGHT_WIDTH-1:0] TGT_W0 = TRK_W0[WEIGHT_WIDTH-1:0];
  localparam logic signed [WEIGHT_WIDTH-1:0] TGT_W1 = TRK_W1[WEIGHT_WIDTH-1:0];
  localparam logic signed [WEIGHT_WIDTH-1:0] TGT_W2 = TRK_W2[WEIGHT_WIDTH-1:0];
  localparam logic signed [WEIGHT_WIDTH-1:0] TGT_W3 = TRK_W3[WEIGHT_WIDTH-1:0];

  // One extra bit so |err| = 2^(E-1) compares correctly against thresholds.
  localparam logic [ERROR_WIDTH:0] LOCK_TH   = LOCK_THRESH[ERROR_WIDTH:0];
  localparam logic [ERROR_WIDTH:0] UNLOCK_TH = UNLOCK_THRESH[ERROR_WIDTH:0];

  // Counter values on which the next qualifying sample completes the count.
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);

  state_t                         r_state;
  logic signed [WEIGHT_WIDTH-1:0] r_w0, r_w1, r_w2, r_w3;
  logic [7:0]                     r_lock_cnt;
  logic [7:0]                     r_unlock_cnt;
  logic                           r_locked;

  logic [ERROR_WIDTH-1:0]         w_err_abs;
  logic                           w_in_lock;
  logic                           w_out_lock;
  logic signed [WEIGHT_WIDTH-1:0] w_nxt_w0, w_nxt_w1, w_nxt_w2, w_nxt_w3;
  logic                           w_ramp_done;

  // Move a weight one step toward its target; hold once it is there.
  function automatic logic signed [WEIGHT_WIDTH-1:0] step_toward(
    input logic signed [WEIGHT_WIDTH-1:0] cur,
    input logic signed [WEIGHT_WIDTH-1:0] tgt
  );
    if (cur < tgt)      return cur + WONE;
    else if (cur > tgt) return cur - WONE;
    else                return cur;
  endfunction

  // Magnitude taken modulo 2^E: the most negative error maps to 2^(E-1).
  assign w_err_abs  = bus.error_comb_i[ERROR_WIDTH-1] ? $unsigned(-bus.error_comb_i)
                                                      : $unsigned(bus.error_comb_i);
  assign w_in_lock  = ({1'b0, w_err_abs} <= LOCK_TH);
  assign w_out_lock = ({1'b0, w_err_abs} >  UNLOCK_TH);

  // Candidate ramp step and whether it lands every weight on its target.
  always_comb begin
    w_nxt_w0    = step_toward(r_w0, TGT_W0);
    w_nxt_w1    = step_toward(r_w1, TGT_W1);
    w_nxt_w2    = step_toward(r_w2, TGT_W2);
    w_nxt_w3    = step_toward(r_w3, TGT_W3);
    w_ramp_done = (w_nxt_w0 == TGT_W0) && (w_nxt_w1 == TGT_W1) &&
                  (w_nxt_w2 == TGT_W2) && (w_nxt_w3 == TGT_W3);
  end

  // Acquire / settle / track state machine with registered weights and flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= ST_ACQUIRE;
      r_w0         <= WMAX;
      r_w1         <= WZERO;
      r_w2         <= WZERO;
      r_w3         <= WZERO;
      r_lock_cnt   <= '0;
      r_unlock_cnt <= '0;
      r_locked     <= 1'b0;
    end else if (r_state == ST_UNUSED) begin
      // Illegal encoding recovers without waiting for a sample.
      r_state      <= ST_ACQUIRE;
      r_w0         <= WMAX;
      r_w1         <= WZERO;
      r_w2         <= WZERO;
      r_w3         <= WZERO;
      r_lock_cnt   <= '0;
      r_unlock_cnt <= '0;
      r_locked     <= 1'b0;
    end else if (bus.error_valid_i) begin
      case (r_state)
        ST_ACQUIRE: begin
          r_w0 <= WMAX;
          r_w1 <= WZERO;
          r_w2 <= WZERO;
          r_w3 <= WZERO;
          if (w_in_lock) begin
            if (r_lock_cnt == LOCK_LAST) begin
              r_state    <= ST_SETTLE;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 8'd1;
            end
          end else begin
            r_lock_cnt <= '0;
          end
        end

        ST_SETTLE: begin
          if (w_out_lock) begin
            // Abort: snap back, the step on this sample never happens.
            r_state <= ST_ACQUIRE;
            r_w0    <= WMAX;
            r_w1    <= WZERO;
            r_w2    <= WZERO;
            r_w3    <= WZERO;
          end else begin
            r_w0 <= w_nxt_w0;
            r_w1 <= w_nxt_w1;
            r_w2 <= w_nxt_w2;
            r_w3 <= w_nxt_w3;
            if (w_ramp_done) begin
              r_state  <= ST_TRACK;
              r_locked <= 1'b1;
            end
          end
        end

        ST_TRACK: begin
          if (w_out_lock) begin
            if (r_unlock_cnt == UNLOCK_LAST) begin
              r_state      <= ST_ACQUIRE;
              r_w0         <= WMAX;
              r_w1         <= WZERO;
              r_w2         <= WZERO;
              r_w3         <= WZERO;
              r_locked     <= 1'b0;
              r_lock_cnt   <= '0;
              r_unlock_cnt <= '0;
            end else begin
              r_unlock_cnt <= r_unlock_cnt + 8'd1;
            end
          end else begin
            r_unlock_cnt <= '0;
          end
        end

        default: begin
          r_state <= ST_ACQUIRE;
        end
      endcase
    end
  end

  assign bus.weight_0_o = r_w0;
  assign bus.weight_1_o = r_w1;
  assign bus.weight_2_o = r_w2;
  assign bus.weight_3_o = r_w3;
  assign bus.locked_o   = r_locked;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_weight_scheduler.sv
// Bench for weight_scheduler: directed acquire/ramp/unlock/abort/reset
// sequences followed by random traffic, all checked through an expected queue
// fed by a behavioural model of the scheduler.
module tb_weight_scheduler;

  logic clk;
  logic reset;

  weight_scheduler_if #(.WEIGHT_WIDTH(4), .ERROR_WIDTH(5)) bus ();

  weight_scheduler dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [18:0] exp_q[$];
  int n_chk;
  int n_err;

  // Model state
  int m_state;
  int m_w[4];
  int m_lc;
  int m_uc;
  bit m_locked;
  int trk[4] = '{1, 2, 2, 2};

  function automatic logic [18:0] pack(input int st, input bit lk,
                                       input int w0, input int w1,
                                       input int w2, input int w3);
    return {2'(st), lk, 4'(w0), 4'(w1), 4'(w2), 4'(w3)};
  endfunction

  function automatic logic [18:0] observed();
    return {bus.state_o, bus.locked_o, bus.weight_0_o, bus.weight_1_o,
            bus.weight_2_o, bus.weight_3_o};
  endfunction

  function automatic logic [18:0] model_now();
    return pack(m_state, m_locked, m_w[0], m_w[1], m_w[2], m_w[3]);
  endfunction

  task automatic check_val(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_w      = '{7, 0, 0, 0};
    m_lc     = 0;
    m_uc     = 0;
    m_locked = 0;
  endtask

  task automatic model_sample(input int err);
    int  mag;
    bool_done: begin end
    mag = (err < 0) ? -err : err;
    if (m_state == 0) begin
      if (mag <= 2) begin
        m_lc++;
        if (m_lc == 16) begin
          m_state = 1;
          m_lc    = 0;
        end
      end else begin
        m_lc = 0;
      end
    end else if (m_state == 1) begin
      if (mag > 8) begin
        m_state = 0;
        m_w     = '{7, 0, 0, 0};
      end else begin
        bit all_eq;
        all_eq = 1;
        for (int k = 0; k < 4; k++) begin
          if (m_w[k] < trk[k]) m_w[k]++;
          else if (m_w[k] > trk[k]) m_w[k]--;
          if (m_w[k] != trk[k]) all_eq = 0;
        end
        if (all_eq) begin
          m_state  = 2;
          m_locked = 1;
        end
      end
    end else begin
      if (mag > 8) begin
        m_uc++;
        if (m_uc == 4) begin
          model_reset();
        end
      end else begin
        m_uc = 0;
      end
    end
  endtask

  // Drive one valid sample, predict, then compare one cycle later.
  task automatic send(input string tag, input int err);
    logic [18:0] exp;
    @(negedge clk);
    bus.error_comb_i  = 5'(err);
    bus.error_valid_i = 1'b1;
    model_sample(err);
    exp_q.push_back(model_now());
    @(posedge clk);
    #1;
    bus.error_valid_i = 1'b0;
    if (exp_q.size() == 0) begin
      check_val({tag, "_empty_q"}, observed(), 19'h7ffff);
    end else begin
      exp = exp_q.pop_front();
      check_val(tag, observed(), exp);
    end
  endtask

  // Valid low with garbage on the error bus: everything must hold.
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.error_valid_i = 1'b0;
      bus.error_comb_i  = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      check_val(tag, observed(), model_now());
    end
  endtask

  // Reset pulse entirely between two clock edges.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_val(tag, observed(), pack(0, 0, 7, 0, 0, 0));
    model_reset();
    #1 reset = 1'b0;
  endtask

  function automatic int rand_err();
    int sel;
    sel = int'($urandom_range(0, 3));
    if (sel <= 1)      return int'($urandom_range(0, 4)) - 2;
    else if (sel == 2) return int'($urandom_range(0, 16)) - 8;
    else               return int'($urandom_range(0, 31)) - 16;
  endfunction

  int ramp_w0[6] = '{6, 5, 4, 3, 2, 1};
  int ramp_w1[6] = '{1, 2, 2, 2, 2, 2};

  initial begin
    n_chk = 0;
    n_err = 0;
    bus.error_comb_i  = '0;
    bus.error_valid_i = 1'b0;
    reset = 1'b1;
    model_reset();

    // T1: reset values with no clock edge yet
    #2;
    check_val("t1_reset", observed(), pack(0, 0, 7, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // T2: 15 in-lock then a just-too-large sample keeps ACQUIRE and restarts
    for (int i = 0; i < 15; i++) send("t2_pre", -2);
    send("t2_break", 3);
    check_val("t2_still_acq", {17'd0, bus.state_o}, 19'd0);
    for (int i = 0; i < 15; i++) send("t2_count", 2);
    check_val("t2_not_yet", {17'd0, bus.state_o}, 19'd0);
    send("t2_16th", 2);
    check_val("t2_settle", {17'd0, bus.state_o}, 19'd1);

    // T3: ramp with a frozen stretch after the second step
    for (int i = 0; i < 6; i++) begin
      send("t3_ramp", 0);
      check_val("t3_w0", {15'd0, bus.weight_0_o}, 19'(ramp_w0[i]));
      check_val("t3_w1", {15'd0, bus.weight_1_o}, 19'(ramp_w1[i]));
      if (i == 1) idle("t3_frozen", 10);
    end
    check_val("t3_track", observed(), pack(2, 1, 1, 2, 2, 2));

    // T4: unlock counter clears on a good sample, then 4 bad ones unlock
    for (int i = 0; i < 3; i++) send("t4_neg16", -16);
    send("t4_clear", 0);
    check_val("t4_locked", {18'd0, bus.locked_o}, 19'd1);
    for (int i = 0; i < 3; i++) send("t4_nine", 9);
    check_val("t4_still", observed(), pack(2, 1, 1, 2, 2, 2));
    send("t4_unlock", 9);
    check_val("t4_acq", observed(), pack(0, 0, 7, 0, 0, 0));

    // T5: abort on the third ramp sample
    for (int i = 0; i < 16; i++) send("t5_acq", 0);
    send("t5_r1", 0);
    send("t5_r2", 0);
    send("t5_abort", -9);
    check_val("t5_snap", observed(), pack(0, 0, 7, 0, 0, 0));

    // T6: asynchronous reset while tracking
    for (int i = 0; i < 16; i++) send("t6_acq", 1);
    for (int i = 0; i < 6; i++) send("t6_ramp", -1);
    check_val("t6_track", observed(), pack(2, 1, 1, 2, 2, 2));
    reset_pulse("t6_async");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) != 0) send("rnd", rand_err());
      else idle("rnd_idle", 1);
      if (i == 250) reset_pulse("rnd_reset");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
